data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the core's load/store port: accepts one request at a time over a valid/ready
//  handshake, serves it from an internal word array after a fixed latency, and returns the response over a
//  second valid/ready handshake. Replaces the zero-latency data memory so the core can be moved to handshaked fetch/LSU.
//  Performs byte/half/word lane steering and sign/zero extension using the core's funct3-style size code.
// PARAMETERS
//  DEPTH_WORDS  1024           number of 32-bit words in the array
//  BASE_ADDR    32'h8000_0000  byte address of word 0
//  LATENCY      2              cycles from request accept edge to resp_valid high; legal range 1..15
// PORTS
//  clk         in   1   clock, all state updates on posedge
//  rst_n       in   1   asynchronous active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept (high only in IDLE)
//  req_wen     in   1   1 = store, 0 = load
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, LSB-aligned (byte in [7:0], half in [15:0])
//  req_bits    in   3   size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  resp_valid  out  1   response present
//  resp_ready  in   1   requester takes response
//  resp_rdata  out  32  load data, extended; 0 for stores and errors
//  resp_err    out  1   access error flag, qualified by resp_valid
// BEHAVIOUR
//  - Interface: one clock clk; reset rst_n asynchronous, active-low. Reset forces IDLE: req_ready=1,
//    resp_valid=0, resp_rdata=0, resp_err=0. Array contents are NOT reset.
//  - FSM IDLE -> WAIT -> RESP -> IDLE. Accept = req_valid & req_ready; latch wen/addr/wdata/bits, load
//    cnt=LATENCY-1. LATENCY=1 goes IDLE->RESP directly. WAIT decrements cnt, enters RESP when cnt==1.
//  - On the edge entering RESP: store commits to array; load data captured into resp_rdata; resp_err set.
//  - RESP holds resp_valid/rdata/err stable until resp_ready; handshake edge -> IDLE. Next accept earliest one
//    cycle later (no accept in same cycle as response handshake). resp_ready ignored outside RESP.
//  - Lane rules: B/BU use addr[1:0] byte lane; H/HU use addr[1] half lane; W whole word.
//    Store B writes only the addressed byte, H only the addressed half. Load B/H sign-extend, BU/HU zero-extend.
//  - Errors (resp_err=1, rdata=0, no array write): addr outside BASE_ADDR..BASE_ADDR+4*DEPTH_WORDS-1;
//    req_bits in {011,110,111}; store with req_bits BU/HU.
//  - Word index = (addr-BASE_ADDR)>>2, width $clog2(DEPTH_WORDS); no wrap, out-of-range is an error.
//  - req_valid while not IDLE: ignored, request fields not sampled; requester must hold them until accepted.
//  - Reset mid-transaction: pending request dropped; uncommitted store never written.
// CONFIGURATION
//  MEM_RESP_MISALIGN_EN defined: H/HU with addr[0]=1, or W with addr[1:0]!=0 -> resp_err=1, rdata=0, no write.
//  Undefined: misaligned low address bits silently ignored (H uses addr[1], W uses word); resp_err=0.
// STRUCTURE
//  mem_resp_pkg: FSM state enum (IDLE/WAIT/RESP), size-code constants MB_B/MB_H/MB_W/MB_BU/MB_HU,
//   LATENCY counter width constant.
//  Sub-module mem_lane_align (combinational): size code + addr[1:0] + data -> byte-enable[3:0],
//   shifted store word, extended load value, size-code error flag.
// TESTING
//  1 LATENCY=2, sw 0xDEADBEEF @0x8000_0000 accepted at cycle t -> resp_valid at t+2, err=0; lw same -> 0xDEADBEEF.
//  2 sb 0x80 @0x8000_0005 over word 0x11223344 @0x8000_0004 -> word 0x11228044; lb @0x8000_0005 -> 0xFFFFFF80; lbu -> 0x00000080.
//  3 lw @0x7FFF_FFFC and sw @BASE+4*DEPTH_WORDS -> resp_err=1, rdata=0, array unchanged (read back old value).
//  4 resp_ready held low 5 cycles in RESP -> resp_valid/rdata stable, req_ready=0; new req_valid not accepted.
//  5 lh @0x8000_0002 with macro -> err=1; without macro, data 0xABCD1234 @0x8000_0000 -> rdata 0xFFFFABCD.
//  6 rst_n pulsed low while in WAIT of sw 0x5 @0x8000_0008 (old 0x0) -> outputs to reset values; lw reads 0x0.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] MB_B  = 3'b000;
  localparam logic [2:0] MB_H  = 3'b001;
  localparam logic [2:0] MB_W  = 3'b010;
  localparam logic [2:0] MB_BU = 3'b100;
  localparam logic [2:0] MB_HU = 3'b101;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int unsigned LAT_CNT_W = 4;

endpackage

// File: rtl/mem_lane_align.sv
// Byte/half/word lane steering and load extension for the responder.
// MEM_RESP_MISALIGN_EN: flag H/HU with addr[0]=1 and W with addr[1:0]!=0 as errors.
module mem_lane_align
  import mem_resp_pkg::*;
(
  input  logic [2:0]  i_bits,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata,
  output logic        o_size_err,
  output logic        o_align_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_misalign;

  always_comb begin
    w_byte = '0;
    case (i_addr_lo)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      default: w_byte = i_rword[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
  end

  always_comb begin
    o_be       = '0;
    o_wword    = '0;
    o_rdata    = '0;
    o_size_err = 1'b0;
    w_misalign = 1'b0;
    case (i_bits)
      MB_B, MB_BU: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wword = {4{i_wdata[7:0]}};
        o_rdata = (i_bits == MB_B) ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
      end
      MB_H, MB_HU: begin
        o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wword    = {2{i_wdata[15:0]}};
        o_rdata    = (i_bits == MB_H) ? {{16{w_half[15]}}, w_half} : {16'b0, w_half};
        w_misalign = i_addr_lo[0];
      end
      MB_W: begin
        o_be       = 4'b1111;
        o_wword    = i_wdata;
        o_rdata    = i_rword;
        w_misalign = |i_addr_lo;
      end
      default: o_size_err = 1'b1;
    endcase
  end

`ifdef MEM_RESP_MISALIGN_EN
  assign o_align_err = w_misalign;
`else
  assign o_align_err = 1'b0;
`endif

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency valid/ready data memory responder with lane steering and error reporting.
// MEM_RESP_MISALIGN_EN (see mem_lane_align) turns misaligned H/W accesses into errors.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_bits,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0]          SPAN     = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [LAT_CNT_W-1:0] CNT_INIT = LAT_CNT_W'(LATENCY - 1);
  localparam logic                 LAT_ONE  = (LATENCY == 1);

  state_t               r_state;
  logic [LAT_CNT_W-1:0] r_cnt;
  logic                 r_wen;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [2:0]           r_bits;
  logic                 r_req_ready;
  logic                 r_resp_valid;
  logic [31:0]          r_resp_rdata;
  logic                 r_resp_err;
  logic [31:0]          r_mem [DEPTH_WORDS];

  logic              w_idle;
  logic              w_accept;
  logic              w_enter_resp;
  logic              w_wen;
  logic [31:0]       w_addr;
  logic [31:0]       w_wdata;
  logic [2:0]        w_bits;
  logic [31:0]       w_offset;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic [31:0]       w_rword;
  logic [3:0]        w_be;
  logic [31:0]       w_wword;
  logic [31:0]       w_load;
  logic              w_size_err;
  logic              w_align_err;
  logic              w_err;
  logic              w_commit;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = req_valid & r_req_ready;

  // With LATENCY=1 the response is formed on the accept edge, so decode from the live request.
  assign w_wen   = w_idle ? req_wen   : r_wen;
  assign w_addr  = w_idle ? req_addr  : r_addr;
  assign w_wdata = w_idle ? req_wdata : r_wdata;
  assign w_bits  = w_idle ? req_bits  : r_bits;

  assign w_enter_resp = (w_idle & w_accept & LAT_ONE) |
                        ((r_state == ST_WAIT) & (r_cnt == LAT_CNT_W'(1)));

  assign w_offset   = w_addr - BASE_ADDR;
  assign w_in_range = ({1'b0, w_offset} < SPAN);
  assign w_idx      = w_offset[IDX_W+1:2];
  assign w_rword    = r_mem[w_idx];

  mem_lane_align u_align (
    .i_bits      (w_bits),
    .i_addr_lo   (w_addr[1:0]),
    .i_wdata     (w_wdata),
    .i_rword     (w_rword),
    .o_be        (w_be),
    .o_wword     (w_wword),
    .o_rdata     (w_load),
    .o_size_err  (w_size_err),
    .o_align_err (w_align_err)
  );

  assign w_err    = ~w_in_range | w_size_err | (w_wen & w_bits[2]) | w_align_err;
  assign w_commit = w_enter_resp & w_wen & ~w_err & rst_n;

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_bits       <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_wen       <= req_wen;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_bits      <= req_bits;
            r_cnt       <= CNT_INIT;
            r_req_ready <= 1'b0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != LAT_CNT_W'(1)) r_cnt <= r_cnt - LAT_CNT_W'(1);
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Overrides the WAIT transition above on the edge the response is formed.
      if (w_enter_resp) begin
        r_state      <= ST_RESP;
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_err;
        r_resp_rdata <= (w_err | w_wen) ? '0 : w_load;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule
